// File: rtl/vertex_accum_buffer_pkg.sv
// rtl/vertex_accum_buffer_pkg.sv - default sizes and per-bank packet types for the vertex accumulation buffer
package vertex_accum_buffer_pkg;

    localparam int DEF_NUM_BANK = 4;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 8;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } in_pkt_t;

    typedef struct packed {
        logic                  req;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } out_pkt_t;

endpackage

// File: rtl/vertex_accum_buffer_if.sv
// rtl/vertex_accum_buffer_if.sv - per-bank push and SRAM-write handshake bundle
interface vertex_accum_buffer_if
    import vertex_accum_buffer_pkg::*;
#(
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
);
    logic [NUM_BANK-1:0]        in_valid;
    logic [NUM_BANK*ADDR_W-1:0] in_addr;
    logic [NUM_BANK*DATA_W-1:0] in_data;
    logic [NUM_BANK-1:0]        in_ready;
    logic [NUM_BANK-1:0]        out_req;
    logic [NUM_BANK*ADDR_W-1:0] out_addr;
    logic [NUM_BANK*DATA_W-1:0] out_data;
    logic [NUM_BANK-1:0]        req_grant;

    modport master (
        output in_valid, in_addr, in_data, req_grant,
        input  in_ready, out_req, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, req_grant,
        output in_ready, out_req, out_addr, out_data
    );
endinterface

// File: rtl/vertex_accum_bank.sv
// rtl/vertex_accum_bank.sv - one circular (addr, data) FIFO bank with same-address tail coalescing
module vertex_accum_bank
    import vertex_accum_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accum_en,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_grant,
    output logic              push_ready,
    output logic              head_req,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, tail_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_pop, do_push, do_coal, accepted;

    assign full       = (count == CNT_W'(DEPTH));
    assign push_ready = ~full;
    assign head_req   = (count != '0);
    // Memories are not reset, so gate the head view to keep outputs zero while empty.
    assign head_addr  = head_req ? addr_mem[rd_ptr] : '0;
    assign head_data  = head_req ? data_mem[rd_ptr] : '0;
    assign tail_ptr   = wr_ptr - 1'b1;

    assign do_pop   = head_req & pop_grant;
    assign accepted = push_valid & push_ready;
    // A lone entry leaving this cycle cannot absorb the push; it becomes a fresh entry instead.
    assign do_coal  = accepted & accum_en & head_req & (addr_mem[tail_ptr] == push_addr)
                    & ~((count == CNT_W'(1)) & do_pop);
    assign do_push  = accepted & ~do_coal;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_valid & ~push_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
            end else if (do_coal) begin
                data_mem[tail_ptr] <= data_mem[tail_ptr] + push_data;
            end
        end
    end
endmodule

// File: rtl/vertex_accum_buffer.sv
// rtl/vertex_accum_buffer.sv - NUM_BANK independent vertex accumulation FIFOs feeding SRAM write ports
module vertex_accum_buffer
    import vertex_accum_buffer_pkg::*;
#(
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 accum_en,
    vertex_accum_buffer_if.slave bus,
    output logic                 empty,
    output logic [NUM_BANK-1:0]  bank_full,
    output logic [NUM_BANK-1:0]  overflow_err
);
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        vertex_accum_bank #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .accum_en   (accum_en),
            .push_valid (bus.in_valid[b]),
            .push_addr  (bus.in_addr[b*ADDR_W +: ADDR_W]),
            .push_data  (bus.in_data[b*DATA_W +: DATA_W]),
            .pop_grant  (bus.req_grant[b]),
            .push_ready (bus.in_ready[b]),
            .head_req   (bus.out_req[b]),
            .head_addr  (bus.out_addr[b*ADDR_W +: ADDR_W]),
            .head_data  (bus.out_data[b*DATA_W +: DATA_W]),
            .full       (bank_full[b]),
            .overflow   (overflow_err[b])
        );
    end

    assign empty = ~|bus.out_req;
endmodule

// File: doc/vertex_accum_buffer.md
VERTEX_ACCUM_BUFFER -- requirements
Module: vertex_accum_buffer

Interface
REQ-001 Parameter NUM_BANK, default 4: number of independent vertex banks (channels).
REQ-002 Parameter DEPTH, default 8: entries per bank FIFO; power of two, >= 2.
REQ-003 Parameter DATA_W, default 16: vertex accumulation data width.
REQ-004 Parameter ADDR_W, default 8: output SRAM address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  NUM_BANK  per-bank push request.
REQ-008 in_addr  input  NUM_BANK*ADDR_W  per-bank destination address.
REQ-009 in_data  input  NUM_BANK*DATA_W  per-bank vertex partial sum.
REQ-010 accum_en  input  1  coalesce mode: add same-address pushes into tail entry.
REQ-011 req_grant  input  NUM_BANK  per-bank output SRAM write grant.
REQ-012 in_ready  output  NUM_BANK  bank can accept a push (count < DEPTH).
REQ-013 out_req  output  NUM_BANK  bank head entry valid, requesting SRAM write.
REQ-014 out_addr  output  NUM_BANK*ADDR_W  head entry address.
REQ-015 out_data  output  NUM_BANK*DATA_W  head entry data.
REQ-016 empty  output  1  all banks hold zero entries.
REQ-017 bank_full  output  NUM_BANK  count == DEPTH per bank.
REQ-018 overflow_err  output  NUM_BANK  sticky: push attempted while not ready.

Function
REQ-019 Each bank SHALL be an independent circular FIFO of (addr, data) entries with wr_ptr, rd_ptr wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-020 Push SHALL occur when in_valid[b] & in_ready[b]; in_ready[b] SHALL be ~bank_full[b], derived from registered count only (no same-cycle pop bypass).
REQ-021 Coalesce SHALL occur instead of push when accum_en, count>=1, in_addr equals tail entry addr, and NOT (count==1 and head popped this cycle); tail data becomes tail data + in_data modulo 2^DATA_W; count and pointers unchanged.
REQ-022 Coalesce SHALL also require in_ready (full bank rejects even coalescible pushes).
REQ-023 out_req[b] SHALL be (count != 0); out_addr/out_data SHALL present entry at rd_ptr, registered state only.
REQ-024 Pop SHALL occur when out_req[b] & req_grant[b]; grant with out_req low SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Latency: data pushed in cycle N SHALL appear on out_req/out_data no earlier than cycle N+1 (when it is head).
REQ-027 Coalesce into an entry that is also head SHALL be visible on out_data next cycle.
REQ-028 in_valid & ~in_ready SHALL drop the data and set overflow_err[b] until reset.
REQ-029 empty SHALL be NOR of all out_req; bank_full per REQ-017, both from registered counts.
REQ-030 Banks SHALL not interact; per-bank behaviour independent of other banks' traffic.

Reset
REQ-031 On reset: counts, pointers, overflow_err cleared; out_req=0, in_ready=all 1, empty=1, bank_full=0; out_addr/out_data=0.
REQ-032 Reset mid-operation SHALL discard all stored entries; in_valid/req_grant in the reset cycle ignored.

Structure
REQ-033 Shared package SHALL hold per-bank input and output packet typedefs (valid/addr/data, req/addr/data) and default parameter constants.
REQ-034 One sub-module vertex_accum_bank SHALL implement a single bank; top instantiates NUM_BANK copies via generate and reduces empty.

Verification
REQ-035 Fill bank 0 with 8 distinct addrs, accum_en=0, no grant -> bank_full[0]=1, in_ready[0]=0; 9th push -> overflow_err[0]=1, FIFO contents unchanged.
REQ-036 accum_en=1, push addr 0x10 data 5 then addr 0x10 data 7 -> one entry, out_data=12, count 1.
REQ-037 DATA_W=16, coalesce 0xFFFF + 0x0002 -> out_data=0x0001.
REQ-038 count==1, head addr 0x20 granted while push addr 0x20 data 3 -> new entry data 3, count stays 1.
REQ-039 Continuous push+grant for 20 cycles on bank 2 -> pointers wrap, in-order output, count constant, banks 0/1/3 unaffected.
REQ-040 Reset asserted with entries in all banks -> next cycle empty=1, out_req=0, overflow_err=0.
